// File: rtl/nubus_mem2wb_pkg.sv
// Shared definitions for the NuBus card-side memory bus bridges: FSM state
// encoding and Wishbone select helper.
package nubus_mem2wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // Reads fetch the whole word; writes pass the byte enables straight through.
    function automatic logic [3:0] wb_sel_for(input logic [3:0] mem_write);
        return (|mem_write) ? mem_write : 4'hF;
    endfunction

endpackage

// File: rtl/nubus_mem2wb_wdt.sv
// nubus_wdt: clear/enable watchdog counter with a one-cycle expiry strobe.
// Expiry fires on the enabled edge that carries the count to all-ones.
module nubus_wdt #(
    parameter int W = 10
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/nubus_mem2wb.sv
// NuBus slave memory access -> single classic Wishbone B3 master cycle.
// Optional watchdog enabled by defining NUBUS_MEM2WB_TIMEOUT_EN.
module nubus_mem2wb
    import nubus_mem2wb_pkg::*;
#(
    parameter int WB_ADR_W  = 30,
    parameter int TIMEOUT_W = 10
) (
    input  logic                nub_clk,
    input  logic                nub_reset,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_write,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic                mem_error,
    output logic                mem_tryagain,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic                wb_we,
    output logic [3:0]          wb_sel,
    output logic [WB_ADR_W-1:0] wb_adr,
    output logic [31:0]         wb_dat_w,
    input  logic [31:0]         wb_dat_r,
    input  logic                wb_ack,
    input  logic                wb_err
);

    state_t state_reg, state_next;

    logic                cyc_reg;
    logic                we_reg;
    logic [3:0]          sel_reg;
    logic [WB_ADR_W-1:0] adr_reg;
    logic [31:0]         dat_w_reg;
    logic [31:0]         rdata_reg;
    logic                ready_reg;
    logic                error_reg;

    logic start;
    logic complete;
    logic silent_end;
    logic timeout;
    logic wdt_expire;
    logic addr_unused;

    generate
        if (WB_ADR_W < 30) begin : g_addr_narrow
            assign addr_unused = ^{mem_addr[31:WB_ADR_W+2], mem_addr[1:0]};
        end else begin : g_addr_full
            assign addr_unused = ^mem_addr[1:0];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        complete   = 1'b0;
        silent_end = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_valid) begin
                    start      = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                // A slave answer always beats the watchdog; if the master has
                // already given up, nobody is left to receive mem_ready.
                if (wb_ack || wb_err) begin
                    if (mem_valid) begin
                        complete   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        silent_end = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (wdt_expire) begin
                    if (mem_valid) begin
                        timeout    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        silent_end = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (!mem_valid) begin
                    state_next = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (wb_ack || wb_err || wdt_expire) begin
                    silent_end = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!mem_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            adr_reg   <= '0;
            dat_w_reg <= '0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= complete || timeout;
            error_reg <= complete && wb_err;
            if (start) begin
                cyc_reg   <= 1'b1;
                we_reg    <= |mem_write;
                sel_reg   <= wb_sel_for(mem_write);
                adr_reg   <= mem_addr[WB_ADR_W+1:2];
                dat_w_reg <= mem_wdata;
            end
            if (complete || silent_end || timeout) begin
                cyc_reg <= 1'b0;
            end
            if (complete && !we_reg) begin
                rdata_reg <= wb_dat_r;
            end
        end
    end

`ifdef NUBUS_MEM2WB_TIMEOUT_EN
    logic tryagain_reg;

    nubus_wdt #(
        .W (TIMEOUT_W)
    ) u_wdt (
        .clk    (nub_clk),
        .srst   (nub_reset),
        .clr    (start),
        .en     ((state_reg == ST_BUS) || (state_reg == ST_ABORT)),
        .expire (wdt_expire)
    );

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            tryagain_reg <= 1'b0;
        end else begin
            tryagain_reg <= timeout;
        end
    end

    assign mem_tryagain = tryagain_reg;
`else
    assign wdt_expire   = 1'b0;
    assign mem_tryagain = 1'b0;
`endif

    assign wb_cyc    = cyc_reg;
    assign wb_stb    = cyc_reg;
    assign wb_we     = we_reg;
    assign wb_sel    = sel_reg;
    assign wb_adr    = adr_reg;
    assign wb_dat_w  = dat_w_reg;
    assign mem_rdata = rdata_reg;
    assign mem_ready = ready_reg;
    assign mem_error = error_reg;

endmodule

// File: tb/tb_nubus_mem2wb.sv
// Directed self-checking bench for nubus_mem2wb; the watchdog scenario runs
// only when NUBUS_MEM2WB_TIMEOUT_EN is defined.
module tb_nubus_mem2wb;

    logic        nub_clk = 1'b0;
    logic        nub_reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_write;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_tryagain;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 nub_clk = ~nub_clk;

    nubus_mem2wb #(
        .WB_ADR_W  (30),
        .TIMEOUT_W (4)
    ) dut (
        .nub_clk      (nub_clk),
        .nub_reset    (nub_reset),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_error    (mem_error),
        .mem_tryagain (mem_tryagain),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_adr       (wb_adr),
        .wb_dat_w     (wb_dat_w),
        .wb_dat_r     (wb_dat_r),
        .wb_ack       (wb_ack),
        .wb_err       (wb_err)
    );

    // Advance one clock and settle just past the edge, where inputs change
    // and outputs are sampled.
    task automatic tick();
        @(posedge nub_clk);
        #1;
    endtask

    task automatic test_reset();
        nub_reset = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = '0;
        wb_dat_r  = '0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({wb_cyc, wb_stb, wb_we, mem_ready, mem_error, mem_tryagain} !== 6'b0)
            $display("FAIL reset_ctl got %b want 000000",
                     {wb_cyc, wb_stb, wb_we, mem_ready, mem_error, mem_tryagain});
        else pass_cnt++;
        total_cnt++;
        if ({wb_sel, wb_adr, wb_dat_w, mem_rdata} !== '0)
            $display("FAIL reset_data sel=%h adr=%h dw=%h rd=%h want all 0",
                     wb_sel, wb_adr, wb_dat_w, mem_rdata);
        else pass_cnt++;
        nub_reset = 1'b0;
        tick();
        $display("reset: ctl=%b", {wb_cyc, mem_ready});
    endtask

    task automatic test_read_zero_wait();
        mem_valid = 1'b1;
        mem_addr  = 32'hF5C00010;
        mem_write = 4'b0000;
        tick();
        total_cnt++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel, mem_ready} !== 8'b11_0_1111_0)
            $display("FAIL rd_wb_ctl got cyc=%b stb=%b we=%b sel=%h rdy=%b want 1 1 0 f 0",
                     wb_cyc, wb_stb, wb_we, wb_sel, mem_ready);
        else pass_cnt++;
        total_cnt++;
        if (wb_adr !== 30'h3D700004)
            $display("FAIL rd_adr got %h want 3d700004", wb_adr);
        else pass_cnt++;
        wb_ack   = 1'b1;
        wb_dat_r = 32'hDEADBEEF;
        tick();
        total_cnt++;
        if ({mem_ready, mem_error, wb_cyc} !== 3'b100 || mem_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_done got rdy=%b err=%b cyc=%b rd=%h want 1 0 0 deadbeef",
                     mem_ready, mem_error, wb_cyc, mem_rdata);
        else pass_cnt++;
        wb_ack   = 1'b0;
        wb_dat_r = 32'h0;
        tick();
        total_cnt++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_pulse got rdy=%b rd=%h want 0 deadbeef", mem_ready, mem_rdata);
        else pass_cnt++;
        mem_valid = 1'b0;
        tick();
        $display("read zero-wait: rdata=%h", mem_rdata);
    endtask

    task automatic test_write_wait();
        bit stable = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 32'h00001234;
        mem_wdata = 32'h00AB0000;
        mem_write = 4'b0100;
        tick();
        for (int i = 0; i < 6; i++) begin
            if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'b111_0100 || wb_adr !== 30'h48D ||
                wb_dat_w !== 32'h00AB0000 || mem_ready !== 1'b0)
                stable = 1'b0;
            if (i == 5) wb_ack = 1'b1;
            tick();
        end
        total_cnt++;
        if (!stable)
            $display("FAIL wr_stable got unstable wishbone outputs want constant we=1 sel=4 for 6 cycles");
        else pass_cnt++;
        total_cnt++;
        if ({mem_ready, mem_error, wb_cyc} !== 3'b100 || mem_rdata !== 32'hDEADBEEF)
            $display("FAIL wr_done got rdy=%b err=%b cyc=%b rd=%h want 1 0 0 deadbeef",
                     mem_ready, mem_error, wb_cyc, mem_rdata);
        else pass_cnt++;
        wb_ack    = 1'b0;
        mem_valid = 1'b0;
        mem_write = 4'b0000;
        tick();
        $display("write 5 wait states: stable=%0b", stable);
    endtask

    task automatic test_ack_err();
        mem_valid = 1'b1;
        mem_addr  = 32'h00000040;
        tick();
        wb_ack   = 1'b1;
        wb_err   = 1'b1;
        wb_dat_r = 32'h12345678;
        tick();
        total_cnt++;
        if ({mem_ready, mem_error, mem_tryagain} !== 3'b110)
            $display("FAIL ackerr got rdy=%b err=%b try=%b want 1 1 0",
                     mem_ready, mem_error, mem_tryagain);
        else pass_cnt++;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        tick();
        total_cnt++;
        if ({mem_ready, mem_error} !== 2'b00)
            $display("FAIL ackerr_clear got rdy=%b err=%b want 0 0", mem_ready, mem_error);
        else pass_cnt++;
        mem_valid = 1'b0;
        tick();
        $display("ack+err: error reported");
    endtask

    task automatic test_back_to_back();
        int cyc_seen = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h00000080;
        tick();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_cyc) cyc_seen++;
        end
        total_cnt++;
        if (cyc_seen !== 0)
            $display("FAIL b2b_hold got %0d busy cycles want 0", cyc_seen);
        else pass_cnt++;
        mem_valid = 1'b0;
        tick();
        total_cnt++;
        if (wb_cyc !== 1'b0)
            $display("FAIL b2b_gap got cyc=%b want 0", wb_cyc);
        else pass_cnt++;
        mem_valid = 1'b1;
        tick();
        total_cnt++;
        if (wb_cyc !== 1'b1)
            $display("FAIL b2b_restart got cyc=%b want 1", wb_cyc);
        else pass_cnt++;
        wb_ack = 1'b1;
        tick();
        wb_ack    = 1'b0;
        mem_valid = 1'b0;
        tick();
        $display("back-to-back: extra busy cycles=%0d", cyc_seen);
    endtask

    task automatic test_abort();
        int ready_seen = 0;
        int cyc_low    = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h00000100;
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!wb_cyc) cyc_low++;
            if (mem_ready) ready_seen++;
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        if (mem_ready) ready_seen++;
        total_cnt++;
        if (cyc_low !== 0)
            $display("FAIL abort_hold got %0d idle cycles before ack want 0", cyc_low);
        else pass_cnt++;
        total_cnt++;
        if (wb_cyc !== 1'b0)
            $display("FAIL abort_drop got cyc=%b want 0", wb_cyc);
        else pass_cnt++;
        tick();
        if (mem_ready) ready_seen++;
        total_cnt++;
        if (ready_seen !== 0)
            $display("FAIL abort_ready got %0d pulses want 0", ready_seen);
        else pass_cnt++;
        mem_valid = 1'b1;
        tick();
        total_cnt++;
        if (wb_cyc !== 1'b1)
            $display("FAIL abort_idle got cyc=%b want 1", wb_cyc);
        else pass_cnt++;
        wb_ack = 1'b1;
        tick();
        wb_ack    = 1'b0;
        mem_valid = 1'b0;
        tick();
        $display("abort: ready pulses=%0d", ready_seen);
    endtask

    task automatic test_reset_mid_bus();
        mem_valid = 1'b1;
        mem_addr  = 32'hFFFFFFFC;
        mem_wdata = 32'hCAFEF00D;
        mem_write = 4'b1111;
        tick();
        tick();
        nub_reset = 1'b1;
        tick();
        total_cnt++;
        if ({wb_cyc, wb_we, mem_ready, wb_sel} !== 7'b0 || wb_adr !== '0 ||
            wb_dat_w !== '0 || mem_rdata !== '0)
            $display("FAIL rst_mid got cyc=%b we=%b rdy=%b sel=%h adr=%h dw=%h rd=%h want all 0",
                     wb_cyc, wb_we, mem_ready, wb_sel, wb_adr, wb_dat_w, mem_rdata);
        else pass_cnt++;
        nub_reset = 1'b0;
        mem_valid = 1'b0;
        mem_write = 4'b0000;
        tick();
        $display("reset mid-bus: cyc=%b", wb_cyc);
    endtask

`ifdef NUBUS_MEM2WB_TIMEOUT_EN
    task automatic test_timeout();
        int busy = 0;
        mem_valid = 1'b1;
        mem_addr  = 32'h00000200;
        tick();
        while (wb_cyc && busy < 40) begin
            busy++;
            tick();
        end
        total_cnt++;
        if (busy !== 15)
            $display("FAIL tmo_len got %0d busy cycles want 15", busy);
        else pass_cnt++;
        total_cnt++;
        if ({mem_ready, mem_tryagain, mem_error} !== 3'b110)
            $display("FAIL tmo_status got rdy=%b try=%b err=%b want 1 1 0",
                     mem_ready, mem_tryagain, mem_error);
        else pass_cnt++;
        mem_valid = 1'b0;
        tick();
        $display("timeout: busy cycles=%0d", busy);
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_ack_err();
        test_back_to_back();
        test_abort();
        test_reset_mid_bus();
`ifdef NUBUS_MEM2WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
